fifo_drain_checker: RTL and testbench
=====================================

Name: fifo_drain_checker

Overview:
- Read-side companion to the FIFO write-pattern generator.
- Waits for the FIFO to report almost-full, then drains it in one burst until it is empty.
- Checks every word read against the incrementing pattern the writer produces (0,1,2,... mod 2^DATA_W).
- Exposes status and error counters for the on-chip logic analyzer; sits between the FIFO IP read port and the debug probes.

Parameters:
- DATA_W, 8, FIFO data width.
- SETTLE_CYC, 10, cycles waited after almost_full is seen before reading starts. Lets the FIFO flags settle.
- RD_LATENCY, 1, cycles from fifo_rd_en high to fifo_rdata valid. Legal values 1 or 2.
- CNT_W, 16, width of word and error counters.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- fifo_almost_full  in  1  FIFO almost-full flag
- fifo_almost_empty  in  1  FIFO almost-empty flag; status only, not used for control
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata  in  DATA_W  FIFO read data
- fifo_rd_en  out  1  FIFO read enable
- busy  out  1  high in SETTLE or READ
- burst_done  out  1  one-cycle pulse when a drain burst ends
- word_cnt  out  CNT_W  total words checked; wraps modulo 2^CNT_W
- err_cnt  out  CNT_W  mismatched words; saturates at all-ones
- err_flag  out  1  sticky; set on first mismatch

Behaviour:
- Reset: while sys_rst is sampled high, all of the following hold.
  - fifo_rd_en=0, busy=0, burst_done=0.
  - word_cnt=0, err_cnt=0, err_flag=0.
  - Expected value=0, state=IDLE, latency pipeline cleared.
  - Reset mid-burst aborts immediately; words already in flight are discarded and not checked.
- States: IDLE, SETTLE, READ.
  - IDLE: fifo_rd_en=0. Go to SETTLE when fifo_almost_full=1. Load the settle counter with SETTLE_CYC-1.
  - SETTLE: count down to 0, then go to READ. SETTLE_CYC=0 is treated as 1. almost_full dropping during SETTLE does not abort.
  - READ: fifo_rd_en = ~fifo_empty, combinational from the current state and flag. fifo_rd_en is never high while fifo_empty=1. On the first cycle fifo_empty=1 in READ: go to IDLE and pulse burst_done for that cycle.
  - A READ entered with fifo_empty already 1 exits on its first cycle with zero reads and still pulses burst_done.
- Read fire: rd_fire = fifo_rd_en.
  - rd_fire is delayed through an RD_LATENCY-deep shift register to form dvalid.
  - On dvalid, fifo_rdata is compared to the expected value.
  - Words still in the pipeline after the READ→IDLE transition are still checked.
- Checking, on each dvalid cycle:
  - word_cnt increments by 1.
  - Match: expected ← expected+1 (mod 2^DATA_W).
  - Mismatch: err_flag ← 1; err_cnt increments unless it is all-ones; expected ← fifo_rdata+1 (resync, so one dropped word counts as one error, not a stream of errors).
- Expected value is not reset between bursts; the pattern continues across bursts.
- Wrap: expected 2^DATA_W-1 → 0 is a match, not an error.
- Simultaneous almost_full=1 in the cycle READ exits: the FSM goes to IDLE first, then SETTLE on the following cycle. There is no direct READ→SETTLE transition.

Test Plan:
- Reset then idle: sys_rst high for 3 cycles, flags quiet → all outputs 0; fifo_rd_en stays 0 for 100 cycles.
- Clean burst: model FIFO preloaded with 0..253, almost_full asserted → fifo_rd_en rises 11 cycles after almost_full is first sampled; 254 reads; burst_done pulses once; word_cnt=254, err_cnt=0, err_flag=0.
- Dropped word: FIFO contents 0..9 then 11..20 → err_cnt=1, err_flag=1, word_cnt=20, and no further errors.
- Wrap across two bursts: burst 1 is 0..199, burst 2 is 200..255 then 0..99 → err_cnt=0, word_cnt=356.
- Empty at READ entry: almost_full pulses for 1 cycle, but fifo_empty=1 when READ is entered → zero reads, burst_done pulses, state returns to IDLE.
- Reset mid-READ after 50 words, then a fresh burst of 0..99 → counters restart; word_cnt=100, err_cnt=0, err_flag=0.

Source files
------------

// File: rtl/fifo_drain_checker_if.sv
// FIFO read-port bundle between the FIFO IP and the drain checker.
//   master : the reader (drives fifo_rd_en, observes flags and data)
//   slave  : the FIFO   (drives flags and data, observes fifo_rd_en)
interface fifo_drain_checker_if #(
    parameter int unsigned DATA_W = 8
);
    logic              fifo_almost_full;
    logic              fifo_almost_empty;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_rd_en;

    modport master (
        input  fifo_almost_full,
        input  fifo_almost_empty,
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd_en
    );

    modport slave (
        output fifo_almost_full,
        output fifo_almost_empty,
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_drain_checker.sv
// Drains a FIFO in one burst once it reports almost-full and checks every word
// against an incrementing pattern (0,1,2,... mod 2^DATA_W).
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   fifo             : FIFO read port (master side; fifo_rd_en is combinational)
//   busy             : high in SETTLE or READ
//   burst_done       : one-cycle pulse in the cycle a drain burst ends
//   word_cnt         : words checked, wraps
//   err_cnt          : mismatched words, saturates
//   err_flag         : sticky mismatch flag
module fifo_drain_checker #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETTLE_CYC = 10,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    fifo_drain_checker_if.master fifo,
    output logic                busy,
    output logic                burst_done,
    output logic [CNT_W-1:0]    word_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                err_flag
);

    // SETTLE_CYC=0 behaves as 1; read latency clamped to the legal 1..2.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
    localparam int unsigned SETTLE_W   = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_EFF - 1);
    localparam int unsigned LAT        = (RD_LATENCY == 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        READ   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                rd_en_c;
    logic [LAT-1:0]      pipe_q;
    logic                dvalid;
    logic [DATA_W-1:0]   expected_q;

    // State and settle-counter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next state and combinational outputs; everything is forced low in reset
    // so a reset landing mid-burst stops reads in the same cycle.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        rd_en_c    = 1'b0;
        busy       = 1'b0;
        burst_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo.fifo_almost_full) begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_q == '0) begin
                    state_d = READ;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            READ: begin
                busy = 1'b1;
                if (fifo.fifo_empty) begin
                    state_d    = IDLE;
                    burst_done = 1'b1;
                end else begin
                    rd_en_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sys_rst) begin
            rd_en_c    = 1'b0;
            busy       = 1'b0;
            burst_done = 1'b0;
        end
    end

    assign fifo.fifo_rd_en = rd_en_c;

    // Read-fire delay line; its tail marks the cycle fifo_rdata is valid.
    if (LAT == 1) begin : g_lat1
        always_ff @(posedge sys_clk) begin
            if (sys_rst) pipe_q <= '0;
            else         pipe_q <= rd_en_c;
        end
    end else begin : g_latn
        always_ff @(posedge sys_clk) begin
            if (sys_rst) pipe_q <= '0;
            else         pipe_q <= {pipe_q[LAT-2:0], rd_en_c};
        end
    end

    assign dvalid = pipe_q[LAT-1];

    // Pattern check; on mismatch resync to the received word so a single
    // dropped word costs exactly one error.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            expected_q <= '0;
            word_cnt   <= '0;
            err_cnt    <= '0;
            err_flag   <= 1'b0;
        end else if (dvalid) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (fifo.fifo_rdata == expected_q) begin
                expected_q <= expected_q + DATA_W'(1);
            end else begin
                expected_q <= fifo.fifo_rdata + DATA_W'(1);
                err_flag   <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_checker.sv
// Bench for fifo_drain_checker: a behavioural FIFO model with 1-cycle read
// latency, table-driven bursts, and hand-written multi-cycle sequences.
module tb_fifo_drain_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        af  = 1'b0;
    logic        busy, burst_done, err_flag;
    logic [15:0] word_cnt, err_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:1023];
    int         rd_ptr = 0;
    int         wr_ptr = 0;

    fifo_drain_checker_if #(.DATA_W(8)) ifc ();

    fifo_drain_checker #(
        .DATA_W(8), .SETTLE_CYC(10), .RD_LATENCY(1), .CNT_W(16)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .fifo      (ifc),
        .busy      (busy),
        .burst_done(burst_done),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on rd_en, data valid the following cycle.
    assign ifc.fifo_empty        = (rd_ptr == wr_ptr);
    assign ifc.fifo_almost_empty = ((wr_ptr - rd_ptr) < 4);
    assign ifc.fifo_almost_full  = af;

    always @(posedge clk) begin
        if (ifc.fifo_rd_en) begin
            ifc.fifo_rdata <= mem[rd_ptr % 1024];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    typedef struct {
        int first;
        int len;
        int skip_at;
        bit rst_before;
        int exp_words;
        int exp_errs;
        int exp_flag;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Push a run of pattern words; from index skip_at onward one value is skipped.
    task automatic load(input int first, input int len, input int skip_at);
        int v;
        for (int i = 0; i < len; i++) begin
            v = first + i + ((skip_at >= 0 && i >= skip_at) ? 1 : 0);
            mem[wr_ptr % 1024] = 8'(v);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr_ptr = rd_ptr;
        rst = 1'b0;
    endtask

    // Raise almost_full for one sampled edge, then run a full drain burst.
    task automatic run_burst(input string tag, input int exp_reads);
        int edges = 0;
        int reads = 0;
        int dones = 0;
        int cyc   = 0;
        bit seen  = 0;
        af = 1'b1;
        while (!seen && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) af = 1'b0;
            if (ifc.fifo_rd_en) seen = 1;
        end
        chk({tag, "_rd_en_latency"}, edges, 11);
        if (seen) reads = 1;
        while (dones == 0 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (ifc.fifo_rd_en) reads++;
            if (burst_done) dones++;
        end
        repeat (5) begin
            @(posedge clk); #1;
            if (ifc.fifo_rd_en) reads++;
            if (burst_done) dones++;
        end
        chk({tag, "_reads"}, reads, exp_reads);
        chk({tag, "_burst_done_pulses"}, dones, 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        int edges;
        int reads;
        bit seen;

        vecs[0] = '{0,   254, -1, 1'b1, 254, 0, 0};
        vecs[1] = '{0,   20,  10, 1'b1, 20,  1, 1};
        vecs[2] = '{0,   200, -1, 1'b1, 200, 0, 0};
        vecs[3] = '{200, 156, -1, 1'b0, 356, 0, 0};

        // Reset held 3 cycles, then 100 quiet cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en",      int'(ifc.fifo_rd_en), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_burst_done", int'(burst_done), 0);
        chk("rst_word_cnt",   int'(word_cnt), 0);
        chk("rst_err_cnt",    int'(err_cnt), 0);
        chk("rst_err_flag",   int'(err_flag), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (ifc.fifo_rd_en || busy) cnt++;
        end
        chk("idle_activity", cnt, 0);

        // Table-driven bursts.
        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            if (vecs[k].rst_before) do_reset();
            load(vecs[k].first, vecs[k].len, vecs[k].skip_at);
            @(posedge clk); #1;
            run_burst(tag, vecs[k].len);
            chk({tag, "_word_cnt"}, int'(word_cnt), vecs[k].exp_words);
            chk({tag, "_err_cnt"},  int'(err_cnt),  vecs[k].exp_errs);
            chk({tag, "_err_flag"}, int'(err_flag), vecs[k].exp_flag);
        end

        // FIFO empty when READ is entered: zero reads, burst_done still pulses.
        af = 1'b1;
        @(posedge clk); #1;
        af = 1'b0;
        edges = 1; reads = 0; seen = 0;
        while (!seen && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (ifc.fifo_rd_en) reads++;
            if (burst_done) seen = 1;
        end
        chk("empty_done_cycle", edges, 11);
        chk("empty_reads", reads, 0);
        @(posedge clk); #1;
        chk("empty_busy_after", int'(busy), 0);
        chk("empty_word_cnt", int'(word_cnt), 356);

        // almost_full held through READ exit: IDLE for one cycle, then SETTLE.
        load(100, 5, -1);
        @(posedge clk); #1;
        af = 1'b1;
        cnt = 0; seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (burst_done) seen = 1;
        end
        chk("hold_first_done", int'(seen), 1);
        @(posedge clk); #1;
        chk("hold_idle_gap_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("hold_resettle_busy", int'(busy), 1);
        af = 1'b0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (burst_done) seen = 1;
        end
        chk("hold_second_done", int'(seen), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_word_cnt", int'(word_cnt), 361);
        chk("hold_err_cnt",  int'(err_cnt), 0);

        // Reset in the middle of a READ burst, then a fresh clean burst.
        load(0, 150, -1);
        @(posedge clk); #1;
        af = 1'b1;
        edges = 0; reads = 0;
        while (reads < 50 && edges < 400) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) af = 1'b0;
            if (ifc.fifo_rd_en) reads++;
        end
        chk("midrst_reads_before", reads, 50);
        rst = 1'b1;
        #1;
        chk("midrst_rd_en_in_reset", int'(ifc.fifo_rd_en), 0);
        @(posedge clk); #1;
        chk("midrst_word_cnt", int'(word_cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #1;
        wr_ptr = rd_ptr;
        rst = 1'b0;
        load(0, 100, -1);
        @(posedge clk); #1;
        run_burst("post_rst", 100);
        chk("post_rst_word_cnt", int'(word_cnt), 100);
        chk("post_rst_err_cnt",  int'(err_cnt), 0);
        chk("post_rst_err_flag", int'(err_flag), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
